cacheline_arbiter: RTL and testbench

Arbitrates the pipeline's two L1 caches for one shared physical-memory port. The instruction cache is read-only and the data cache is read/write; both move 256-bit cachelines. The block sits between the IF/MEM-stage caches and the memory or L2 port. It grants one requester at a time, latches that transaction, and routes the response back to it.

---
 rtl/cacheline_arbiter_if.sv | 43 ++++
 rtl/cacheline_arbiter.sv | 121 ++++++++++++
 tb/tb_cacheline_arbiter.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cacheline_arbiter_if.sv
// Cache/memory bus bundle for the cacheline arbiter.
// slave: arbiter side; master: caches and memory side.
interface cacheline_arbiter_if #(
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
);
    logic                  i_read;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic [LINE_WIDTH-1:0] i_rdata;
    logic                  i_resp;
    logic                  d_read;
    logic                  d_write;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [LINE_WIDTH-1:0] d_wdata;
    logic [LINE_WIDTH-1:0] d_rdata;
    logic                  d_resp;
    logic                  pmem_read;
    logic                  pmem_write;
    logic [ADDR_WIDTH-1:0] pmem_addr;
    logic [LINE_WIDTH-1:0] pmem_wdata;
    logic [LINE_WIDTH-1:0] pmem_rdata;
    logic                  pmem_resp;

    modport slave (
        input  i_read, i_addr,
        input  d_read, d_write, d_addr, d_wdata,
        input  pmem_rdata, pmem_resp,
        output i_rdata, i_resp,
        output d_rdata, d_resp,
        output pmem_read, pmem_write,
        output pmem_addr, pmem_wdata
    );

    modport master (
        output i_read, i_addr,
        output d_read, d_write, d_addr, d_wdata,
        output pmem_rdata, pmem_resp,
        input  i_rdata, i_resp,
        input  d_rdata, d_resp,
        input  pmem_read, pmem_write,
        input  pmem_addr, pmem_wdata
    );
endinterface

// File: rtl/cacheline_arbiter.sv
// Shares one memory port between icache and dcache.
// Define ARBITER_RR_EN for round-robin, else dcache priority.
module cacheline_arbiter #(
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
) (
    input  logic clk,
    input  logic rst,
    cacheline_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
    logic                  write_q, write_d;

    logic i_req;
    logic d_req;
    logic grant_d;

    logic                  pmem_read;
    logic                  pmem_write;
    logic [ADDR_WIDTH-1:0] pmem_addr;
    logic [LINE_WIDTH-1:0] pmem_wdata;
    logic                  i_resp;
    logic                  d_resp;

`ifdef ARBITER_RR_EN
    logic last_q, last_d;
`endif

    assign i_req = bus.i_read;
    assign d_req = bus.d_read | bus.d_write;

    // Pick the winner: grant_d=1 selects the dcache.
    always_comb begin
        grant_d = d_req;
`ifdef ARBITER_RR_EN
        if (i_req && d_req) begin
            grant_d = ~last_q;
        end
`endif
    end

    // Next state, transaction capture and bus outputs.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        write_d    = write_q;
`ifdef ARBITER_RR_EN
        last_d     = last_q;
`endif
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        pmem_addr  = '0;
        pmem_wdata = '0;
        i_resp     = 1'b0;
        d_resp     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    state_d = grant_d ? SERVE_D : SERVE_I;
                    addr_d  = grant_d ? bus.d_addr : bus.i_addr;
                    wdata_d = grant_d ? bus.d_wdata : '0;
                    write_d = grant_d & bus.d_write;
`ifdef ARBITER_RR_EN
                    last_d  = grant_d;
`endif
                end
            end
            SERVE_I, SERVE_D: begin
                pmem_read  = ~write_q;
                pmem_write = write_q;
                pmem_addr  = addr_q;
                pmem_wdata = wdata_q;
                if (bus.pmem_resp) begin
                    i_resp  = (state_q == SERVE_I);
                    d_resp  = (state_q == SERVE_D);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latched transaction registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
`ifdef ARBITER_RR_EN
            last_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
`ifdef ARBITER_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    assign bus.pmem_read  = pmem_read;
    assign bus.pmem_write = pmem_write;
    assign bus.pmem_addr  = pmem_addr;
    assign bus.pmem_wdata = pmem_wdata;
    assign bus.i_resp     = i_resp;
    assign bus.d_resp     = d_resp;
    assign bus.i_rdata    = bus.pmem_rdata;
    assign bus.d_rdata    = bus.pmem_rdata;
endmodule

// File: tb/tb_cacheline_arbiter.sv
// Bench for cacheline_arbiter: vectors, corner sequences,
// and random traffic against a transaction-level model.
module tb_cacheline_arbiter;
    localparam int LW = 256;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    cacheline_arbiter_if #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) bus ();

    cacheline_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string          name;
        bit             ir;
        bit             dr;
        bit             dw;
        logic [AW-1:0]  addr;
        logic [LW-1:0]  wd;
        int             lat;
        bit             exp_d;
        bit             exp_wr;
        logic [AW-1:0]  exp_addr;
        logic [LW-1:0]  exp_wd;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [LW-1:0] act,
                       input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_line(output logic [LW-1:0] v);
        for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, " idle rd"}, bus.pmem_read, 1'b0);
        chk({tag, " idle wr"}, bus.pmem_write, 1'b0);
        chk({tag, " idle addr"}, bus.pmem_addr, '0);
        chk({tag, " idle wdata"}, bus.pmem_wdata, '0);
        chk({tag, " idle iresp"}, bus.i_resp, 1'b0);
        chk({tag, " idle dresp"}, bus.d_resp, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.i_read = 1'b0;
        bus.d_read = 1'b0;
        bus.d_write = 1'b0;
        bus.pmem_resp = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Called one cycle after the grant edge; returns in the
    // following IDLE cycle with the winner's request dropped.
    task automatic serve(input bit win_d, input bit exp_wr,
                         input logic [AW-1:0] ea,
                         input logic [LW-1:0] ew,
                         input int lat, input string tag);
        logic [LW-1:0] rd;
        if (win_d) begin
            bus.d_addr  = ~bus.d_addr;
            bus.d_wdata = '0;
        end else begin
            bus.i_addr = ~bus.i_addr;
        end
        for (int c = 0; c <= lat; c++) begin
            rand_line(rd);
            bus.pmem_rdata = rd;
            bus.pmem_resp  = (c == lat);
            #1;
            chk({tag, " pmem_read"}, bus.pmem_read, !exp_wr);
            chk({tag, " pmem_write"}, bus.pmem_write, exp_wr);
            chk({tag, " pmem_addr"}, bus.pmem_addr, ea);
            if (exp_wr) chk({tag, " pmem_wdata"}, bus.pmem_wdata, ew);
            chk({tag, " i_resp"}, bus.i_resp, (c == lat) && !win_d);
            chk({tag, " d_resp"}, bus.d_resp, (c == lat) && win_d);
            if (c == lat) begin
                if (win_d) chk({tag, " d_rdata"}, bus.d_rdata, rd);
                else       chk({tag, " i_rdata"}, bus.i_rdata, rd);
            end
            step();
        end
        bus.pmem_resp = 1'b0;
        if (win_d) begin
            bus.d_read  = 1'b0;
            bus.d_write = 1'b0;
        end else begin
            bus.i_read = 1'b0;
        end
        #1;
        idle_chk(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [LW-1:0] a5;
        logic [LW-1:0] x5a;
        logic [LW-1:0] tmp;
        bit ip, dp, js_i, js_d, last_d, win_d, dwr;
        logic [AW-1:0] ia_s, da_s;
        logic [LW-1:0] dw_s;
        int op;

        a5  = {32{8'hA5}};
        x5a = {32{8'h5A}};
        vecs[0] = '{"ird1000", 1, 0, 0, 32'h0000_1000, '0, 3,
                    0, 0, 32'h0000_1000, '0};
        vecs[1] = '{"dwr2040", 0, 0, 1, 32'h0000_2040, a5, 2,
                    1, 1, 32'h0000_2040, a5};
        vecs[2] = '{"drd3000", 0, 1, 0, 32'h0000_3000, a5, 0,
                    1, 0, 32'h0000_3000, '0};
        vecs[3] = '{"drw4080", 0, 1, 1, 32'h0000_4080, x5a, 1,
                    1, 1, 32'h0000_4080, x5a};
        vecs[4] = '{"irdffc0", 1, 0, 0, 32'hFFFF_FFC0, '0, 1,
                    0, 0, 32'hFFFF_FFC0, '0};

        bus.i_addr = '0;
        bus.d_addr = '0;
        bus.d_wdata = '0;
        bus.pmem_rdata = '0;
        do_reset();
        #1;
        idle_chk("reset");

        // Spurious pmem_resp in IDLE.
        bus.pmem_resp = 1'b1;
        #1;
        idle_chk("spur");
        step();
        bus.pmem_resp = 1'b0;
        #1;
        idle_chk("spur2");

        // Table vectors, one requester at a time.
        foreach (vecs[n]) begin
            step();
            bus.i_read  = vecs[n].ir;
            bus.d_read  = vecs[n].dr;
            bus.d_write = vecs[n].dw;
            if (vecs[n].ir) bus.i_addr = vecs[n].addr;
            else            bus.d_addr = vecs[n].addr;
            bus.d_wdata = vecs[n].wd;
            step();
            serve(vecs[n].exp_d, vecs[n].exp_wr, vecs[n].exp_addr,
                  vecs[n].exp_wd, vecs[n].lat, vecs[n].name);
        end

        // Simultaneous reads after reset: dcache first in both modes.
        do_reset();
        bus.i_read = 1'b1;
        bus.i_addr = 32'h0000_5000;
        bus.d_read = 1'b1;
        bus.d_addr = 32'h0000_6000;
        step();
        serve(1'b1, 1'b0, 32'h0000_6000, '0, 1, "conf1a");
        step();
        serve(1'b0, 1'b0, 32'h0000_5000, '0, 2, "conf1b");

        // Last grant dcache, then conflict.
        step();
        bus.d_read = 1'b1;
        bus.d_addr = 32'h0000_7000;
        step();
        serve(1'b1, 1'b0, 32'h0000_7000, '0, 0, "conf2pre");
        step();
        bus.i_read = 1'b1;
        bus.i_addr = 32'h0000_8000;
        bus.d_read = 1'b1;
        bus.d_addr = 32'h0000_9000;
        step();
`ifdef ARBITER_RR_EN
        serve(1'b0, 1'b0, 32'h0000_8000, '0, 1, "conf2a");
        step();
        serve(1'b1, 1'b0, 32'h0000_9000, '0, 1, "conf2b");
`else
        serve(1'b1, 1'b0, 32'h0000_9000, '0, 1, "conf2a");
        step();
        serve(1'b0, 1'b0, 32'h0000_8000, '0, 1, "conf2b");
`endif

        // Reset while SERVE_D waits; late resp must be dropped.
        step();
        bus.d_write = 1'b1;
        bus.d_addr  = 32'h0000_A000;
        bus.d_wdata = a5;
        step();
        #1;
        chk("rstmid pre wr", bus.pmem_write, 1'b1);
        rst = 1'b1;
        bus.d_write = 1'b0;
        step();
        rst = 1'b0;
        rand_line(tmp);
        bus.pmem_rdata = tmp;
        bus.pmem_resp = 1'b1;
        #1;
        idle_chk("rstmid");
        step();
        bus.pmem_resp = 1'b0;

        // Random traffic against the transaction model.
        do_reset();
        ip = 0; dp = 0; js_i = 0; js_d = 0; last_d = 0; dwr = 0;
        ia_s = '0; da_s = '0; dw_s = '0;
        for (int n = 0; n < 200; n++) begin
            if (!ip && !js_i && $urandom_range(0, 1) == 1) begin
                ip = 1;
                ia_s = $urandom;
                bus.i_read = 1'b1;
                bus.i_addr = ia_s;
            end
            if (!dp && !js_d && $urandom_range(0, 1) == 1) begin
                dp = 1;
                op = $urandom_range(1, 3);
                da_s = $urandom;
                rand_line(dw_s);
                dwr = op[1];
                bus.d_read  = op[0];
                bus.d_write = op[1];
                bus.d_addr  = da_s;
                bus.d_wdata = dw_s;
            end
            js_i = 0;
            js_d = 0;
            if (!ip && !dp) begin
                bus.pmem_resp = ($urandom_range(0, 1) == 1);
                #1;
                idle_chk("rnd empty");
                step();
                bus.pmem_resp = 1'b0;
                continue;
            end
`ifdef ARBITER_RR_EN
            win_d = dp && (!ip || !last_d);
`else
            win_d = dp;
`endif
            step();
            if (win_d)
                serve(1'b1, dwr, da_s, dw_s, $urandom_range(0, 4), "rnd d");
            else
                serve(1'b0, 1'b0, ia_s, '0, $urandom_range(0, 4), "rnd i");
            last_d = win_d;
            if (win_d) begin
                dp = 0;
                js_d = 1;
            end else begin
                ip = 0;
                js_i = 1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
